piso_serializer: RTL and testbench

//   Parallel-in/serial-out converter feeding the serial delay-line stage: accepts

---
 rtl/piso_serializer.sv | 149 ++++++++++++++
 tb/tb_piso_serializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out converter with a valid/ready input
// handshake. It emits one bit per clock on o_dout and frames the stream with
// o_dout_valid and o_sof. Back-to-back words stream with no idle gap.
//
// Optional feature: define PISO_PARITY_EN to append one even-parity bit
// (^word) after the WIDTH data bits of every frame. The frame is then
// WIDTH+1 bits long. Without the macro, a frame is exactly WIDTH bits and
// no parity logic is built.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_dout,
    output logic             o_dout_valid,
    output logic             o_sof,
    output logic             o_busy
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    // The counter is sized to hold WIDTH, so the parity slot also fits.
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

`ifdef PISO_PARITY_EN
    localparam logic [CW-1:0] LAST_DATA_CNT = CW'(WIDTH - 1);
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] shift_q;
    logic             dout_q;
    logic             dout_valid_q;
    logic             sof_q;
`ifdef PISO_PARITY_EN
    logic             parity_q;
`endif

    logic             in_last_bit;
    logic             accept;

    // Bit-order dependent values.
    // "load" values apply when a new word is accepted.
    // "next" values apply when the frame in progress advances by one bit.
    logic             load_bit_d;
    logic [WIDTH-1:0] load_shift_d;
    logic             next_bit_d;
    logic [WIDTH-1:0] next_shift_d;

    // o_ready depends only on state and count. This keeps the handshake
    // free of combinational loops through i_valid.
    assign in_last_bit  = (state_q == S_SHIFT) && (count_q == LAST_CNT);
    assign o_ready      = (state_q == S_IDLE) || in_last_bit;
    assign accept       = i_valid && o_ready;
    assign o_busy       = (state_q != S_IDLE);

    assign o_dout       = dout_q;
    assign o_dout_valid = dout_valid_q;
    assign o_sof        = sof_q;

    // The first bit goes straight into the output register on accept. The
    // shift register therefore holds only the bits still to be sent, and
    // zeros are shifted in behind them.
    generate
        if (MSB_FIRST) begin : g_msb_first
            // MSB-first: take the top bit and shift toward the MSB end.
            always_comb begin
                load_bit_d   = i_data[WIDTH-1];
                load_shift_d = {i_data[WIDTH-2:0], 1'b0};
                next_bit_d   = shift_q[WIDTH-1];
                next_shift_d = {shift_q[WIDTH-2:0], 1'b0};
            end
        end else begin : g_lsb_first
            // LSB-first: take bit 0 and shift toward the LSB end.
            always_comb begin
                load_bit_d   = i_data[0];
                load_shift_d = {1'b0, i_data[WIDTH-1:1]};
                next_bit_d   = shift_q[0];
                next_shift_d = {1'b0, shift_q[WIDTH-1:1]};
            end
        end
    endgenerate

    // Framing FSM. It produces the registered serial outputs.
    //
    // Priority of the branches:
    //   1. An accept always starts a new frame. This covers the zero-gap
    //      reload in the last bit cycle.
    //   2. Otherwise the frame advances by one bit.
    //   3. Otherwise, in the last bit cycle, the FSM drops back to idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            shift_q      <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                state_q      <= S_SHIFT;
                count_q      <= '0;
                shift_q      <= load_shift_d;
                dout_q       <= load_bit_d;
                dout_valid_q <= 1'b1;
                sof_q        <= 1'b1;
`ifdef PISO_PARITY_EN
                parity_q     <= ^i_data;
`endif
            end else if ((state_q == S_SHIFT) && !in_last_bit) begin
                count_q      <= count_q + CW'(1);
                shift_q      <= next_shift_d;
                dout_valid_q <= 1'b1;
                sof_q        <= 1'b0;
`ifdef PISO_PARITY_EN
                // After the last data bit, the captured parity bit fills
                // the extra slot.
                dout_q       <= (count_q == LAST_DATA_CNT) ? parity_q : next_bit_d;
`else
                dout_q       <= next_bit_d;
`endif
            end else if (in_last_bit) begin
                state_q      <= S_IDLE;
                count_q      <= '0;
                dout_q       <= 1'b0;
                dout_valid_q <= 1'b0;
                sof_q        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer.
// Two instances share the same stimulus: one sends MSB first and one sends
// LSB first. Expected bit sequences are hand-written in a vector table.
`timescale 1ns/1ps
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME_L = WIDTH + 1;
`else
    localparam int FRAME_L = WIDTH;
`endif

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] data;
    logic             valid;

    logic ready_m, dout_m, dv_m, sof_m, busy_m;
    logic ready_l, dout_l, dv_l, sof_l, busy_l;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data       (data),
        .i_valid      (valid),
        .o_ready      (ready_m),
        .o_dout       (dout_m),
        .o_dout_valid (dv_m),
        .o_sof        (sof_m),
        .o_busy       (busy_m)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data       (data),
        .i_valid      (valid),
        .o_ready      (ready_l),
        .o_dout       (dout_l),
        .o_dout_valid (dv_l),
        .o_sof        (sof_l),
        .o_busy       (busy_l)
    );

    // Each record holds a word and the bits expected on o_dout in time
    // order. Bit [7] of a sequence is emitted first.
    typedef struct {
        logic [7:0] data;
        logic [7:0] seq_msb;
        logic [7:0] seq_lsb;
        logic       parity;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Checks that both instances show idle / reset outputs.
    task automatic chk_idle(input string tag);
        chk($sformatf("%s msb dout", tag),  dout_m,  1'b0);
        chk($sformatf("%s msb dv", tag),    dv_m,    1'b0);
        chk($sformatf("%s msb sof", tag),   sof_m,   1'b0);
        chk($sformatf("%s msb busy", tag),  busy_m,  1'b0);
        chk($sformatf("%s msb ready", tag), ready_m, 1'b1);
        chk($sformatf("%s lsb dout", tag),  dout_l,  1'b0);
        chk($sformatf("%s lsb dv", tag),    dv_l,    1'b0);
        chk($sformatf("%s lsb sof", tag),   sof_l,   1'b0);
        chk($sformatf("%s lsb busy", tag),  busy_l,  1'b0);
        chk($sformatf("%s lsb ready", tag), ready_l, 1'b1);
    endtask

    // Checks one frame-bit cycle (bit index k) on both instances.
    task automatic chk_bit(input string tag, input int k, input logic em,
                           input logic el, input logic last);
        chk($sformatf("%s k=%0d msb dout", tag, k),  dout_m,  em);
        chk($sformatf("%s k=%0d lsb dout", tag, k),  dout_l,  el);
        chk($sformatf("%s k=%0d msb dv", tag, k),    dv_m,    1'b1);
        chk($sformatf("%s k=%0d lsb dv", tag, k),    dv_l,    1'b1);
        chk($sformatf("%s k=%0d msb sof", tag, k),   sof_m,   (k == 0));
        chk($sformatf("%s k=%0d lsb sof", tag, k),   sof_l,   (k == 0));
        chk($sformatf("%s k=%0d msb ready", tag, k), ready_m, last);
        chk($sformatf("%s k=%0d lsb ready", tag, k), ready_l, last);
        chk($sformatf("%s k=%0d msb busy", tag, k),  busy_m,  1'b1);
        chk($sformatf("%s k=%0d lsb busy", tag, k),  busy_l,  1'b1);
    endtask

    // Sends a single isolated word and checks every cycle of its frame,
    // then checks the return to idle.
    task automatic run_frame(input vec_t v, input string tag);
        logic em, el;
        @(negedge clk);
        chk_idle($sformatf("%s pre", tag));
        valid = 1'b1;
        data  = v.data;
        @(posedge clk);              // accepting edge (cycle 0)
        @(negedge clk);              // cycle 1
        valid = 1'b0;
        data  = ~v.data;             // must not disturb the frame
        for (int k = 0; k < FRAME_L; k++) begin
            em = (k < WIDTH) ? v.seq_msb[7-k] : v.parity;
            el = (k < WIDTH) ? v.seq_lsb[7-k] : v.parity;
            chk_bit(tag, k, em, el, (k == FRAME_L - 1));
            @(negedge clk);
        end
        chk_idle($sformatf("%s post", tag));
        $display("frame %s data=%h", tag, v.data);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, seq_msb: 8'b10100101, seq_lsb: 8'b10100101, parity: 1'b0};
        vecs[1] = '{data: 8'h01, seq_msb: 8'b00000001, seq_lsb: 8'b10000000, parity: 1'b1};
        vecs[2] = '{data: 8'h12, seq_msb: 8'b00010010, seq_lsb: 8'b01001000, parity: 1'b0};
        vecs[3] = '{data: 8'hF0, seq_msb: 8'b11110000, seq_lsb: 8'b00001111, parity: 1'b0};
        vecs[4] = '{data: 8'h07, seq_msb: 8'b00000111, seq_lsb: 8'b11100000, parity: 1'b1};
        vecs[5] = '{data: 8'h03, seq_msb: 8'b00000011, seq_lsb: 8'b11000000, parity: 1'b0};

        valid = 1'b0;
        data  = '0;
        rst_n = 1'b1;

        // Reset: asserted asynchronously, before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk_idle("reset async");
        repeat (3) @(negedge clk);
        chk_idle("reset held");
        rst_n = 1'b1;
        $display("reset released");

        // Single isolated frames from the table.
        for (int i = 0; i < 6; i++)
            run_frame(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: 0xFF then 0x00 with i_valid held high.
        @(negedge clk);
        valid = 1'b1;
        data  = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        data = 8'h00;
        for (int k = 0; k < FRAME_L; k++) begin
            chk_bit("b2b f1", k, (k < WIDTH), (k < WIDTH), (k == FRAME_L - 1));
            @(negedge clk);
        end
        valid = 1'b0;
        for (int k = 0; k < FRAME_L; k++) begin
            chk_bit("b2b f2", k, 1'b0, 1'b0, (k == FRAME_L - 1));
            @(negedge clk);
        end
        chk_idle("b2b post");
        $display("frame b2b data=ff,00");

        // Reset in the middle of a frame: 0xC3, reset asserted in cycle 4.
        @(negedge clk);
        valid = 1'b1;
        data  = 8'hC3;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_bit("midrst", k, (k < 2), (k < 2), 1'b0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk_idle("midrst asserted");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_idle($sformatf("midrst release c%0d", c));
        end
        $display("frame midrst data=c3 aborted");

        // The first accept after reset must start a clean frame.
        run_frame(vecs[0], "post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
